// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally
// and queues {pc, insn, fault} entries in a 2-entry buffer for decode.
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h01000000,
  parameter logic [31:0] MEM_BYTES = 32'h00100000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_fault
);
  localparam logic [31:0] PC_LAST = PC_RESET + MEM_BYTES - 32'd4;
  localparam logic [31:0] NOP     = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } fetch_ent_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  fetch_ent_t  fbuf [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic        pc_legal, pop, fetch;
  fetch_ent_t  head, push_ent;

  assign imem_address    = pc;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = '0;

  assign pc_legal = (pc[1:0] == 2'b00) && (pc >= PC_RESET) && (pc <= PC_LAST);
  assign pop      = if_valid && if_ready;
  assign fetch    = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);

  // An illegal PC is not issued; a NOP-shaped fault marker goes to decode instead.
  always_comb begin
    push_ent.pc    = pc;
    push_ent.insn  = pc_legal ? imem_data_out : NOP;
    push_ent.fault = !pc_legal;
  end

  assign head     = fbuf[rd_ptr];
  assign if_valid = (count != 2'd0);
  assign if_pc    = if_valid ? head.pc    : '0;
  assign if_insn  = if_valid ? head.insn  : '0;
  assign if_fault = if_valid ? head.fault : 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      pc     <= PC_RESET;
      fbuf   <= '{default: '0};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      // Redirect wins over fetch; a coincident pop is simply discarded with the flush.
      state  <= RUN;
      pc     <= redirect_target;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (fetch) begin
        fbuf[wr_ptr] <= push_ent;
        wr_ptr       <= ~wr_ptr;
        if (pc_legal) pc    <= pc + 32'd4;
        else          state <= HALT;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, fetch} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (default and 16-byte memory) driven by shared
// stimulus, checked every cycle against a queue-style model plus literal checks.
module tb_fetch_unit;
  localparam logic [31:0] PC_RESET = 32'h01000000;
  localparam logic [31:0] BIG_MEM  = 32'h00100000;
  localparam logic [31:0] SML_MEM  = 32'h00000010;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        if_ready = 1'b0;

  logic [31:0] addr [2];
  logic        rw [2];
  logic [31:0] din [2];
  logic [31:0] dout [2];
  logic        vld [2];
  logic [31:0] ipc [2];
  logic [31:0] insn [2];
  logic        flt [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hAAAA0000 + ((a - PC_RESET) >> 2) + 32'd1;
  endfunction

  assign dout[0] = mem(addr[0]);
  assign dout[1] = mem(addr[1]);

  fetch_unit #(.PC_RESET(PC_RESET), .MEM_BYTES(BIG_MEM)) u_big (
    .clock(clock), .reset(reset),
    .imem_address(addr[0]), .imem_read_write(rw[0]), .imem_data_in(din[0]),
    .imem_data_out(dout[0]),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(vld[0]), .if_ready(if_ready), .if_pc(ipc[0]), .if_insn(insn[0]),
    .if_fault(flt[0]));

  fetch_unit #(.PC_RESET(PC_RESET), .MEM_BYTES(SML_MEM)) u_sml (
    .clock(clock), .reset(reset),
    .imem_address(addr[1]), .imem_read_write(rw[1]), .imem_data_in(din[1]),
    .imem_data_out(dout[1]),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(vld[1]), .if_ready(if_ready), .if_pc(ipc[1]), .if_insn(insn[1]),
    .if_fault(flt[1]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Model: buffer is a head-first list of up to two entries; pc and halt flag per instance.
  logic [31:0] m_pc [2];
  bit          m_halt [2];
  int          m_cnt [2];
  ent_t        m_buf [2][2];
  longint      m_mb [2] = '{longint'(BIG_MEM), longint'(SML_MEM)};

  function automatic bit legal(input logic [31:0] a, input longint mb);
    return (a % 4 == 0) && longint'(a) >= longint'(PC_RESET) &&
           longint'(a) + 4 <= longint'(PC_RESET) + mb;
  endfunction

  always @(posedge clock or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_pc[k] = PC_RESET; m_halt[k] = 0; m_cnt[k] = 0;
      end else if (redirect_valid) begin
        m_pc[k] = redirect_target; m_halt[k] = 0; m_cnt[k] = 0;
      end else begin
        if (m_cnt[k] > 0 && if_ready) begin
          m_buf[k][0] = m_buf[k][1];
          m_cnt[k]--;
        end
        if (!m_halt[k] && m_cnt[k] < 2) begin
          if (legal(m_pc[k], m_mb[k])) begin
            m_buf[k][m_cnt[k]] = '{pc: m_pc[k], insn: mem(m_pc[k]), fault: 1'b0};
            m_pc[k] = m_pc[k] + 32'd4;
          end else begin
            m_buf[k][m_cnt[k]] = '{pc: m_pc[k], insn: 32'h00000013, fault: 1'b1};
            m_halt[k] = 1;
          end
          m_cnt[k]++;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      ent_t h;
      h = (m_cnt[k] > 0) ? m_buf[k][0] : '0;
      chk($sformatf("if_valid[%0d]", k), {31'b0, vld[k]}, {31'b0, m_cnt[k] > 0});
      chk($sformatf("if_pc[%0d]", k), ipc[k], h.pc);
      chk($sformatf("if_insn[%0d]", k), insn[k], h.insn);
      chk($sformatf("if_fault[%0d]", k), {31'b0, flt[k]}, {31'b0, h.fault});
      chk($sformatf("imem_address[%0d]", k), addr[k], m_pc[k]);
      chk($sformatf("imem_rw_din[%0d]", k), din[k] | {31'b0, rw[k]}, 32'h0);
    end
  end

  task automatic cyc(input logic rv, input logic [31:0] tgt, input logic rdy);
    redirect_valid = rv; redirect_target = tgt; if_ready = rdy;
    @(posedge clock); #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, {31'b0, vld[0]}, 32'h0);
    chk({name, "_pc"}, ipc[0], 32'h0);
    chk({name, "_insn"}, insn[0], 32'h0);
    chk({name, "_addr"}, addr[0], PC_RESET);
  endtask

  initial begin
    logic [31:0] t;
    // Reset state and first fetches with decode always ready.
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk_zero("rst");
    reset = 1'b1;
    cyc(0, 0, 1);
    chk("first_valid", {31'b0, vld[0]}, 32'h1);
    chk("first_pc", ipc[0], 32'h01000000);
    chk("first_insn", insn[0], 32'hAAAA0001);
    cyc(0, 0, 1);
    chk("second_pc", ipc[0], 32'h01000004);
    chk("second_insn", insn[0], 32'hAAAA0002);
    // Fill the buffer, then assert reset while full.
    repeat (3) cyc(0, 0, 0);
    chk("full_stall_addr", addr[0], 32'h0100000C);
    chk("full_head", ipc[0], 32'h01000004);
    reset = 1'b0; #1;
    chk_zero("mid_rst");
    cyc(0, 0, 0);
    reset = 1'b1;
    // Decode stalled for 5 cycles after reset.
    repeat (5) cyc(0, 0, 0);
    chk("sat_addr", addr[0], 32'h01000008);
    chk("sat_head", ipc[0], 32'h01000000);
    cyc(0, 0, 1);
    chk("drain_pc1", ipc[0], 32'h01000004);
    cyc(0, 0, 1);
    chk("drain_pc2", ipc[0], 32'h01000008);
    chk("drain_insn2", insn[0], 32'hAAAA0003);
    // Redirect coinciding with a pop.
    cyc(1, 32'h01000100, 1);
    chk("redir_bubble", {31'b0, vld[0]}, 32'h0);
    chk("redir_addr", addr[0], 32'h01000100);
    cyc(0, 0, 1);
    chk("redir_pc", ipc[0], 32'h01000100);
    chk("redir_insn", insn[0], 32'hAAAA0041);
    // Misaligned redirect faults and halts until the next redirect.
    cyc(1, 32'h01000102, 0);
    cyc(0, 0, 0);
    chk("mis_valid", {31'b0, vld[0]}, 32'h1);
    chk("mis_pc", ipc[0], 32'h01000102);
    chk("mis_insn", insn[0], 32'h00000013);
    chk("mis_fault", {31'b0, flt[0]}, 32'h1);
    repeat (4) cyc(0, 0, 1);
    chk("halt_valid", {31'b0, vld[0]}, 32'h0);
    chk("halt_addr", addr[0], 32'h01000102);
    cyc(1, PC_RESET, 1);
    chk("resume_bubble", {31'b0, vld[0]}, 32'h0);
    cyc(0, 0, 1);
    chk("resume_pc", ipc[0], 32'h01000000);
    chk("resume_fault", {31'b0, flt[0]}, 32'h0);
    // End of range on the 16-byte instance.
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 1);
      chk("sml_seq_pc", ipc[1], PC_RESET + 32'(4 * i));
      chk("sml_seq_fault", {31'b0, flt[1]}, 32'h0);
    end
    cyc(0, 0, 1);
    chk("sml_end_pc", ipc[1], 32'h01000010);
    chk("sml_end_fault", {31'b0, flt[1]}, 32'h1);
    cyc(0, 0, 1);
    chk("sml_halt", {31'b0, vld[1]}, 32'h0);
    // Randomized traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: t = PC_RESET + 32'(4 * $urandom_range(0, 15));
        3:       t = PC_RESET + 32'($urandom_range(0, 63));
        4:       t = PC_RESET + BIG_MEM - 32'(4 * $urandom_range(1, 3));
        default: t = ($urandom_range(0, 1) == 0) ? PC_RESET - 32'd4 : $urandom;
      endcase
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        cyc(0, 0, 1);
        reset = 1'b1;
      end
      cyc($urandom_range(0, 11) == 0, t, $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory and feeds the decode stage. It owns the program counter and drives a word address into the combinational-read instruction memory every cycle. It captures each returned instruction with its PC into a 2-entry fetch buffer, and presents buffer entries to decode over a valid/ready handshake. It handles control-flow redirects (flush and refetch) and reports misaligned or out-of-range fetches as a fault entry instead of issuing the access.

## Interface
Parameters:
- PC_RESET, 32'h01000000, first fetch address after reset; also the instruction-memory base address.
- MEM_BYTES, 32'h00100000, size of instruction memory in bytes; valid fetch range is [PC_RESET, PC_RESET+MEM_BYTES-4].

Ports:
- clock  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- imem_address  out  32  byte address to instruction memory; equals the current PC.
- imem_read_write  out  1  tied 0 (read only).
- imem_data_in  out  32  tied 0.
- imem_data_out  in  32  instruction word returned combinationally for imem_address in the same cycle.
- redirect_valid  in  1  one-cycle pulse: branch or jump taken.
- redirect_target  in  32  new PC, sampled when redirect_valid=1.
- if_valid  out  1  buffer head valid.
- if_ready  in  1  decode accepts the head this cycle.
- if_pc  out  32  PC of head entry.
- if_insn  out  32  instruction of head entry.
- if_fault  out  1  head entry is a fault marker (misaligned or out-of-range PC).

## Operation
- State registers:
  - pc[31:0];
  - buffer of 2 entries {pc, insn, fault}, with rd_ptr, wr_ptr and count[1:0];
  - FSM in {RUN, HALT}.
- Pop: occurs when if_valid && if_ready. The head entry advances.
- Fetch condition: state==RUN, redirect_valid=0, and (count<2 or pop this cycle).
- Fetch when pc is legal (pc[1:0]==0 and PC_RESET <= pc <= PC_RESET+MEM_BYTES-4):
  - push {pc, imem_data_out, 0};
  - pc <= pc+4.
- Fetch when pc is illegal:
  - push {pc, 32'h00000013, 1};
  - pc is held;
  - state <= HALT.
- HALT: no fetches. Buffered entries, including the fault entry, still drain to decode.
- Redirect (redirect_valid=1), which has priority over any fetch:
  - the buffer is flushed (count <= 0);
  - pc <= redirect_target;
  - state <= RUN, which also exits HALT;
  - no push that cycle.
- Redirect coinciding with a pop: the handshake counts as completed. Decode owns the squash decision for that entry.
- Legality compare is 32-bit unsigned. pc+4 wraps modulo 2^32. A wrapped PC falls outside the legal range and is faulted.
- imem_address = pc at all times, including in HALT and during a redirect cycle. The memory read is harmless because read_write=0.

## Timing
- Reset asserted (async):
  - pc=PC_RESET, count=0, pointers=0, state=RUN;
  - if_valid=0, if_pc=0, if_insn=0, if_fault=0. Head outputs are 0 whenever count==0.
- Reset asserted mid-operation: all state is cleared immediately and the buffer contents are discarded.
- Latency:
  - the fetch of address A occurs in cycle N;
  - the entry for A is visible on if_* in cycle N+1.
- Sustained throughput: with if_ready=1 continuously, one instruction per cycle.
- Full (count==2) with no pop: the fetch stalls and pc holds.
- Full with a pop: fetch proceeds, with simultaneous push and pop; count stays 2.
- Empty with a push: if_valid rises the next cycle, never in the same cycle.
- Redirect penalty: redirect in cycle N → target fetched in N+1 → if_valid with if_pc=target in N+2. if_valid=0 in N+1.
- Back-to-back redirects: the last one wins. Each redirect flushes the buffer again.
- if_* outputs stay stable while if_valid=1 and if_ready=0.

## Test plan
- Reset release with if_ready=1 and memory words 0xAAAA0001, 0xAAAA0002 at PC_RESET and PC_RESET+4 → if_valid=1 from cycle 1. if_pc sequence is 0x01000000, 0x01000004, … and if_insn matches memory; one per cycle.
- Hold if_ready=0 for 5 cycles after reset:
  - count saturates at 2 and pc stops at 0x01000008;
  - on releasing if_ready, entries 0x01000000 and 0x01000004 are delivered, then 0x01000008, with no gaps or duplicates.
- Redirect to 0x01000100 in the same cycle as a pop:
  - the popped entry is accepted;
  - if_valid=0 next cycle;
  - the following cycle if_pc=0x01000100.
- Redirect to 0x01000102 (misaligned):
  - one entry with if_pc=0x01000102, if_insn=0x00000013, if_fault=1;
  - then if_valid stays 0 (HALT) until a redirect to 0x01000000 resumes normal fetch.
- Sequential fetch up to PC_RESET+MEM_BYTES-4 with a small MEM_BYTES=16:
  - the last legal entry has if_fault=0;
  - the next entry has if_pc=0x01000010 with if_fault=1, then HALT.
- Assert reset for one cycle while the buffer is full → outputs are 0 immediately. After release, fetch restarts at 0x01000000.
